// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one NonReversible_ALU between two requesters; one op in flight.
// Legal ops respond LAT cycles after accept, illegal ops the next cycle; response holds until resp_ready.

module NonReversible_ALU (
   input  logic        clk,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c,
   output logic [31:0] mux_result1,
   output logic [31:0] mux_result2,
   output logic [31:0] xor_result,
   output logic [31:0] and_result,
   output logic [31:0] or_result,
   output logic [31:0] add_result,
   output logic [31:0] mux_peres_result,
   output logic [31:0] nand_result,
   output logic [31:0] nor_result
);
   // Results are combinational so that a one-cycle settle latency is usable; clk is kept for the port contract.
   logic clk_unused;
   assign clk_unused = clk;

   assign mux_result1      = (a & ~c) | (b & c);
   assign mux_result2      = (a & c) | (b & ~c);
   assign xor_result       = a ^ b;
   assign and_result       = a & b;
   assign or_result        = a | b;
   assign add_result       = a + b;
   assign mux_peres_result = (a & b) ^ c;
   assign nand_result      = ~(a & b);
   assign nor_result       = ~(a | b);
endmodule

module alu_req_arbiter #(
   parameter int LAT   = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic [31:0]      req0_c,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic [31:0]      req1_c,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [31:0]      resp_data,
   output logic             resp_err,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [3:0] WAIT_INIT = 4'(LAT - 1);

   state_t      state_q, state_d;
   logic [3:0]  wait_cnt;
   logic        last_grant;
   logic [3:0]  op_q;
   logic [31:0] a_q, b_q, c_q;

   logic        gnt_id, accept, op_legal;
   logic [3:0]  acc_op;
   logic [31:0] acc_a, acc_b, acc_c;
   logic [31:0] alu_res;

   logic [31:0] r_mux1, r_mux2, r_xor, r_and, r_or, r_add, r_peres, r_nand, r_nor;

   NonReversible_ALU u_alu (
      .clk              (clk),
      .a                (a_q),
      .b                (b_q),
      .c                (c_q),
      .mux_result1      (r_mux1),
      .mux_result2      (r_mux2),
      .xor_result       (r_xor),
      .and_result       (r_and),
      .or_result        (r_or),
      .add_result       (r_add),
      .mux_peres_result (r_peres),
      .nand_result      (r_nand),
      .nor_result       (r_nor)
   );

   // A lone requester always wins; on a tie the one not granted last goes first.
   always_comb begin
      gnt_id = req1_valid;
      if (req0_valid && req1_valid) gnt_id = ~last_grant;
      req0_ready = (state_q == IDLE) && req0_valid && !gnt_id;
      req1_ready = (state_q == IDLE) && req1_valid && gnt_id;
      accept     = req0_ready || req1_ready;
      acc_op     = gnt_id ? req1_op : req0_op;
      acc_a      = gnt_id ? req1_a  : req0_a;
      acc_b      = gnt_id ? req1_b  : req0_b;
      acc_c      = gnt_id ? req1_c  : req0_c;
      op_legal   = (acc_op <= 4'd8);
   end

   always_comb begin
      alu_res = '0;
      case (op_q)
         4'd0:    alu_res = r_mux1;
         4'd1:    alu_res = r_mux2;
         4'd2:    alu_res = r_xor;
         4'd3:    alu_res = r_and;
         4'd4:    alu_res = r_or;
         4'd5:    alu_res = r_add;
         4'd6:    alu_res = r_peres;
         4'd7:    alu_res = r_nand;
         4'd8:    alu_res = r_nor;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      resp_valid = 1'b0;
      busy       = (state_q != IDLE);
      case (state_q)
         IDLE: if (accept) state_d = op_legal ? WAIT : RESP;
         WAIT: if (wait_cnt == 4'd0) state_d = RESP;
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         wait_cnt   <= 4'd0;
         last_grant <= 1'b1;
         op_q       <= 4'd0;
         a_q        <= '0;
         b_q        <= '0;
         c_q        <= '0;
         resp_id    <= 1'b0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
         op_count   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  last_grant <= gnt_id;
                  resp_id    <= gnt_id;
                  op_q       <= acc_op;
                  a_q        <= acc_a;
                  b_q        <= acc_b;
                  c_q        <= acc_c;
                  wait_cnt   <= WAIT_INIT;
                  if (!op_legal) begin
                     resp_data <= '0;
                     resp_err  <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (wait_cnt == 4'd0) begin
                  resp_data <= alu_res;
                  resp_err  <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            RESP: if (resp_ready) op_count <= op_count + CNT_W'(1);
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed plus randomized bench for alu_req_arbiter against a behavioural arbiter/ALU model.
module tb_alu_req_arbiter;
   localparam int LAT   = 2;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst;
   logic req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req0_c, req1_a, req1_b, req1_c;
   logic resp_valid, resp_ready, resp_id, resp_err, busy;
   logic [31:0] resp_data;
   logic [CNT_W-1:0] op_count;

   int total = 0;
   int bad   = 0;
   int exp_count = 0;
   logic model_last = 1'b1;

   always #5 clk = ~clk;

   alu_req_arbiter #(.LAT(LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_data(resp_data), .resp_err(resp_err), .busy(busy), .op_count(op_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // {err, data} for an opcode, written bit by bit / arithmetically from the opcode table.
   function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
      logic [31:0] r;
      r = '0;
      case (op)
         4'd0: for (int i = 0; i < 32; i++) r[i] = c[i] ? b[i] : a[i];
         4'd1: for (int i = 0; i < 32; i++) r[i] = c[i] ? a[i] : b[i];
         4'd2: r = a ^ b;
         4'd3: r = a & b;
         4'd4: r = a | b;
         4'd5: r = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
         4'd6: for (int i = 0; i < 32; i++) r[i] = (a[i] && b[i]) != c[i];
         4'd7: r = ~(a & b);
         4'd8: r = ~(a | b);
         default: return {1'b1, 32'h0};
      endcase
      return {1'b0, r};
   endfunction

   // Entered one time unit after a rising edge with the DUT idle.
   task automatic transact(input logic v0, input logic v1, input logic [3:0] op0, input logic [3:0] op1,
                           input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] c0,
                           input logic [31:0] a1, input logic [31:0] b1, input logic [31:0] c1,
                           input int stall, input logic keep_loser);
      logic w;
      logic [32:0] e;
      int lat;
      req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0; req0_c = c0;
      req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1; req1_c = c1;
      w = (v0 && v1) ? !model_last : v1;
      #1;
      check("grant", {30'd0, req1_ready, req0_ready}, w ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      model_last = w;
      e = w ? ref_alu(op1, a1, b1, c1) : ref_alu(op0, a0, b0, c0);
      if (w) begin
         req1_valid = 1'b0; req1_op = 4'($urandom); req1_a = $urandom; req1_b = $urandom; req1_c = $urandom;
      end else begin
         req0_valid = 1'b0; req0_op = 4'($urandom); req0_a = $urandom; req0_b = $urandom; req0_c = $urandom;
      end
      if (!keep_loser) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      lat = 0;
      while (!resp_valid && lat < 20) begin
         check("wait_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
         check("wait_busy", busy, 1);
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, e[32] ? 0 : LAT);
      check("resp_id", resp_id, w);
      check("resp_err", resp_err, e[32]);
      check("resp_data", resp_data, e[31:0]);
      for (int s = 0; s < stall; s++) begin
         resp_ready = 1'b0;
         @(posedge clk); #1;
         check("stall_valid", resp_valid, 1);
         check("stall_data", resp_data, e[31:0]);
         check("stall_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
         check("stall_busy", busy, 1);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      exp_count = (exp_count + 1) % (1 << CNT_W);
      check("post_valid", resp_valid, 0);
      check("post_busy", busy, 0);
      check("op_count", op_count, exp_count);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
      exp_count = 0; model_last = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [1:0] v;
      rst = 1'b1;
      req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0; req0_c = '0;
      req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; req1_c = '0;
      resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_resp_valid", resp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_op_count", op_count, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_resp_err", resp_err, 0);
      check("rst_resp_id", resp_id, 0);
      check("rst_readies", {30'd0, req1_ready, req0_ready}, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Single requester, XOR.
      transact(1, 0, 4'd2, 4'd0, 32'hAAAAAAAA, 32'h55555555, 0, 0, 0, 0, 0, 0);
      check("xor_value", resp_data, 32'hFFFFFFFF);

      // Reset in the middle of WAIT discards the op.
      req0_valid = 1'b1; req0_op = 4'd5; req0_a = 32'd10; req0_b = 32'd20;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      check("midwait_busy_pre", busy, 1);
      rst = 1'b1; #1;
      exp_count = 0; model_last = 1'b1;
      check("midwait_busy", busy, 0);
      check("midwait_count", op_count, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("midwait_no_resp", resp_valid, 0);
      end

      // Tie: grants alternate 0,1,0,1.
      for (int k = 0; k < 4; k++)
         transact(1, 1, 4'd3, 4'd7, 32'hAAAAAAAA, 32'h55555555, 0, 32'hAAAAAAAA, 32'h55555555, 0, 0, 1);
      check("tie_count", op_count, 4);

      // Illegal opcode from requester 1.
      transact(0, 1, 4'd0, 4'd12, 0, 0, 0, 32'h1, 32'h2, 32'h3, 0, 0);

      // Response stall with a waiting competitor; requester 0 wins the tie.
      transact(1, 1, 4'd4, 4'd5, 32'h12345678, 32'h9ABCDEF0, 0, 32'h1, 32'h1, 0, 5, 1);
      check("or_value", resp_data, 32'h9ABCDEF8);
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Randomized traffic; counter wraps at 16.
      pulse_reset();
      for (int n = 1; n <= 30; n++) begin
         v = 2'($urandom_range(1, 3));
         transact(v[0], v[1], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                  int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
         if (n == 17) check("wrap17", op_count, 1);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(posedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Shared-access controller for the 32-bit `NonReversible_ALU`. It arbitrates between two requesters using round-robin and issues the winner's operands to one internally instantiated ALU. After a fixed settle latency it captures the selected result and returns it over a valid/ready response channel tagged with the requester ID. One operation is outstanding at a time.

## Interface
Parameters:
- `LAT`, default 2: cycles between operand issue and result capture; legal range 1–15.
- `CNT_W`, default 16: width of the completed-operation counter.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req0_valid`  in  1: requester 0 has an operation pending.
- `req0_ready`  out  1: requester 0 operation accepted this cycle.
- `req0_op`  in  4: requester 0 opcode.
- `req0_a`  in  32: requester 0 operand A.
- `req0_b`  in  32: requester 0 operand B.
- `req0_c`  in  32: requester 0 operand C.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`, `req1_c`: same as requester 0, for requester 1.
- `resp_valid`  out  1: response available.
- `resp_ready`  in  1: consumer takes the response.
- `resp_id`  out  1: requester ID of the response.
- `resp_data`  out  32: captured result.
- `resp_err`  out  1: illegal opcode.
- `busy`  out  1: state is not IDLE.
- `op_count`  out  CNT_W: responses completed since reset.

## Operation
- Opcode map selects the ALU result bus:
  - 0 mux_result1, 1 mux_result2, 2 xor_result, 3 and_result, 4 or_result, 5 add_result, 6 mux_peres_result, 7 nand_result, 8 nor_result.
  - 9–15 are illegal.
- ALU operand inputs are driven from internal registers `a_q`, `b_q`, `c_q`, loaded on accept. The ALU `clk` is tied to `clk`.
- States:
  - IDLE: combinationally assert `reqN_ready` for the granted requester only; the other ready is low.
    - Accept (valid & ready) with a legal op → WAIT, `wait_cnt` = LAT−1.
    - Accept with an illegal op → RESP, `resp_err`=1, `resp_data`=0. The ALU is not waited on.
  - WAIT: `wait_cnt` decrements each cycle.
    - At `wait_cnt`=0, latch the selected result into `resp_data`, set `resp_err`=0, and go to RESP.
  - RESP: `resp_valid`=1. `resp_data`, `resp_id` and `resp_err` are held stable until `resp_ready`=1.
    - On the handshake: increment `op_count` (wraps at 2^CNT_W−1 → 0) and go to IDLE.
- Round-robin grant in IDLE:
  - Only one requester valid → grant it.
  - Both valid → grant the requester that was not granted last.
  - `last_grant` updates on accept only. After reset `last_grant`=1, so requester 0 wins the first tie.
- Requesters hold op and operands stable while valid and not ready. The grant is computed combinationally from the current valids, so a requester may drop valid before acceptance without harm.
- Opcode and ID are registered on accept; later changes on request ports have no effect on the in-flight op.

## Timing
- Reset values: `req0_ready`=0, `req1_ready`=0, `resp_valid`=0, `resp_id`=0, `resp_data`=0, `resp_err`=0, `busy`=0, `op_count`=0; state IDLE; `a_q`, `b_q`, `c_q`=0; `last_grant`=1.
- Accept at edge T. Legal op: `resp_valid` rises after edge T+LAT. Illegal op: `resp_valid` rises after edge T.
- Response consumed at edge R → IDLE. The next accept can occur at edge R+1 at the earliest.
  - Peak throughput: 1 op per LAT+2 cycles (legal) or 2 cycles (illegal).
- `busy` is high from the cycle after accept until the cycle after the response handshake.
- No request is accepted while busy: both readies stay low in WAIT and RESP.
- `resp_ready` held low: state remains RESP indefinitely with outputs stable. Incoming valids are not accepted.
- `rst` asserted in any state: immediate return to reset values. An in-flight response is discarded and `op_count` clears.

## Test plan
- Reset → all outputs 0. Apply req0 only: op=2, A=AAAAAAAA, B=55555555 → `req0_ready` in cycle 1. With LAT=2, `resp_valid`, `resp_id`=0 and `resp_data`=FFFFFFFF appear 2 cycles after accept; `op_count`=1 after the handshake.
- Both valid, req0 op=3, req1 op=7, A=AAAAAAAA, B=55555555, held continuously → grant order 0,1,0,1. Responses: 00000000 (id0), FFFFFFFF (id1), alternating. No starvation.
- req1 op=12 → accept, then `resp_valid` on the next cycle with `resp_err`=1, `resp_data`=0, `resp_id`=1. The ALU result is ignored.
- `resp_ready` held low 5 cycles during RESP for op=4 (A=12345678, B=9ABCDEF0; expected 9ABCDEF8) → `resp_data` stable at 9ABCDEF8, both readies low, `busy`=1. Release → handshake, IDLE.
- `rst` pulsed mid-WAIT → `busy`=0, `resp_valid` never asserts for that op, `op_count`=0. The next request completes normally.
- With CNT_W=4, complete 17 operations → `op_count` reads 1.
